// File: rtl/mult_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | mult_share_arbiter: round-robin sharing of one multiplier among N_REQ   |
// | requesters; latches operands, sequences start/busy, returns product.    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module mult_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_bi,
  input  logic [N_REQ*WIDTH-1:0]   a_bi,
  input  logic [N_REQ*WIDTH-1:0]   b_bi,
  output logic [N_REQ-1:0]         grant_bo,
  output logic [N_REQ-1:0]         done_bo,
  output logic                     err_o,
  output logic [2*WIDTH-1:0]       res_bo,
  output logic                     busy_o,
  output logic                     mul_start_o,
  output logic [WIDTH-1:0]         mul_a_bo,
  output logic [WIDTH-1:0]         mul_b_bo,
  input  logic                     mul_busy_i,
  input  logic [2*WIDTH-1:0]       mul_y_bi
);

  localparam int               PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               err_q, err_d;
  logic               start_q, start_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;

  logic [PTR_W-1:0]   pick;
  logic               pick_vld;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [PTR_W-1:0]   rr_next;
  logic [CNT_W-1:0]   cnt_inc;

  // Scan offsets from high to low so the requester closest to rr_q wins.
  always_comb begin
    logic [PTR_W-1:0] j;
    pick     = rr_q;
    pick_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = PTR_W'((int'(rr_q) + k) % N_REQ);
      if (req_bi[j]) begin
        pick     = j;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == PTR_W'(i)) begin
        sel_a = a_bi[i*WIDTH +: WIDTH];
        sel_b = b_bi[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rr_next = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    start_d = start_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_vld) begin
          a_d     = sel_a;
          b_d     = sel_b;
          owner_d = pick;
          grant_d = N_REQ'(1) << pick;
          start_d = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d = cnt_inc;
        if (mul_busy_i) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (cnt_inc == TIMEOUT_C) begin
          // Multiplier never acknowledged: report an errored, zero result.
          start_d = 1'b0;
          res_d   = '0;
          err_d   = 1'b1;
          done_d  = grant_q;
          grant_d = '0;
          cnt_d   = '0;
          rr_d    = rr_next;
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!mul_busy_i) begin
          res_d   = mul_y_bi;
          done_d  = grant_q;
          grant_d = '0;
          rr_d    = rr_next;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign grant_bo    = grant_q;
  assign done_bo     = done_q;
  assign err_o       = err_q;
  assign res_bo      = res_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign mul_start_o = start_q;
  assign mul_a_bo    = a_q;
  assign mul_b_bo    = b_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mult_share_arbiter: randomized scoreboard bench with a multiplier    |
// | model and a transaction-level round-robin reference.                    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_mult_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 15;

  typedef struct { int idx; logic [2*W-1:0] res; bit err; } done_t;
  typedef struct { int idx; logic [W-1:0] a; logic [W-1:0] b; } grant_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [W-1:0]     a_r [N];
  logic [W-1:0]     b_r [N];
  logic [N*W-1:0]   a_bus, b_bus;
  logic [N-1:0]     grant_bo, done_bo;
  logic             err_o, busy_o, mul_start_o;
  logic [2*W-1:0]   res_bo;
  logic [W-1:0]     mul_a_bo, mul_b_bo;
  logic             mul_busy = 1'b0;
  logic [2*W-1:0]   mul_y = '0;

  done_t  sbq[$];
  grant_t gq[$];
  int     n_vec = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     grant_cyc = 0;
  int     rr_m = 0;
  bit     en = 1'b0;
  bit     m_busy = 1'b0;
  bit     dead = 1'b0;
  logic [N-1:0] pending = '0;

  mult_share_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .req_bi      (req),
    .a_bi        (a_bus),
    .b_bi        (b_bus),
    .grant_bo    (grant_bo),
    .done_bo     (done_bo),
    .err_o       (err_o),
    .res_bo      (res_bo),
    .busy_o      (busy_o),
    .mul_start_o (mul_start_o),
    .mul_a_bo    (mul_a_bo),
    .mul_b_bo    (mul_b_bo),
    .mul_busy_i  (mul_busy),
    .mul_y_bi    (mul_y)
  );

  always #5 clk = ~clk;

  always_comb begin
    a_bus = '0;
    b_bus = '0;
    for (int i = 0; i < N; i++) begin
      a_bus[i*W +: W] = a_r[i];
      b_bus[i*W +: W] = b_r[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Multiplier model: random ack delay and busy length, garbage on y while busy.
  initial begin
    int st, cnt;
    logic [W-1:0] ca, cb;
    st = 0; cnt = 0; ca = '0; cb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st = 0;
        mul_busy = 1'b0;
      end else begin
        case (st)
          0: if (mul_start_o && !dead) begin
               ca  = mul_a_bo;
               cb  = mul_b_bo;
               cnt = $urandom_range(0, 3);
               if (cnt == 0) begin
                 mul_busy = 1'b1;
                 mul_y    = 16'($urandom);
                 cnt      = $urandom_range(1, 5);
                 st       = 2;
               end else begin
                 st = 1;
               end
             end
          1: begin
               cnt--;
               if (cnt == 0) begin
                 mul_busy = 1'b1;
                 mul_y    = 16'($urandom);
                 cnt      = $urandom_range(1, 5);
                 st       = 2;
               end
             end
          default: begin
               cnt--;
               if (cnt == 0) begin
                 mul_busy = 1'b0;
                 mul_y    = {8'h00, ca} * {8'h00, cb};
                 st       = 0;
               end
             end
        endcase
      end
    end
  end

  // Monitor: checks grants and completions against the scoreboard queues.
  initial begin
    logic [N-1:0] pg, pd;
    int wd;
    grant_t g;
    done_t  d;
    pg = '0; pd = '0; wd = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (en) begin
        if (grant_bo != '0 && pg == '0) begin
          if (gq.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL grant_unexpected: got %b expected none", grant_bo);
          end else begin
            g = gq.pop_front();
            chk("grant", 32'(grant_bo), 32'(1) << g.idx);
            chk("mul_a", 32'(mul_a_bo), 32'(g.a));
            chk("mul_b", 32'(mul_b_bo), 32'(g.b));
            chk("start_at_grant", 32'(mul_start_o), 32'd1);
            grant_cyc = cyc;
          end
        end
        if (done_bo != '0) begin
          chk("done_one_cycle", 32'(pd), 32'd0);
          if (sbq.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL done_unexpected: got %b expected none", done_bo);
          end else begin
            d = sbq.pop_front();
            chk("done_bo", 32'(done_bo), 32'(1) << d.idx);
            chk("res", 32'(res_bo), 32'(d.res));
            chk("err", 32'(err_o), 32'(d.err));
            if (d.err) chk("timeout_latency", 32'(cyc - grant_cyc), 32'(TO));
            chk("grant_at_done", 32'(grant_bo), 32'd0);
            chk("busy_at_done", 32'(busy_o), 32'd0);
            rr_m = (d.idx + 1) % N;
          end
          m_busy = 1'b0;
        end else begin
          chk("err_without_done", 32'(err_o), 32'd0);
          if (m_busy) chk("busy_during_job", 32'(busy_o), 32'd1);
        end
        wd = m_busy ? wd + 1 : 0;
        if (wd > 200) begin
          n_vec++; n_fail++;
          $display("FAIL watchdog: job open for %0d cycles, expected completion", wd);
          m_busy = 1'b0;
          sbq.delete();
          gq.delete();
          wd = 0;
        end
      end
      pg = grant_bo;
      pd = done_bo;
    end
  end

  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req[i]     = 1'b1;
    pending[i] = 1'b1;
    a_r[i]     = a;
    b_r[i]     = b;
  endtask

  // Reference: whenever the arbiter is free, the first requester at or after
  // the pointer gets the job, and its product (or an error) is owed back.
  task automatic predict();
    int w;
    logic [2*W-1:0] p;
    w = -1;
    if (!m_busy && req != '0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (rr_m + k) % N;
        if (w < 0 && req[j]) w = j;
      end
      p = {8'h00, a_r[w]} * {8'h00, b_r[w]};
      gq.push_back('{idx: w, a: a_r[w], b: b_r[w]});
      sbq.push_back('{idx: w, res: dead ? '0 : p, err: dead});
      m_busy = 1'b1;
    end
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (done_bo[i]) begin
        pending[i] = 1'b0;
        req[i]     = 1'b0;
      end
    end
  endtask

  task automatic step(input bit rnd);
    sync();
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (grant_bo[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            a_r[i] = 8'($urandom);
            b_r[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
          end
        end else if (!pending[i] && $urandom_range(0, 5) == 0) begin
          raise(i, 8'($urandom), 8'($urandom));
        end
      end
    end
    predict();
  endtask

  task automatic run_idle(input bit rnd, input int maxc);
    int c;
    c = 0;
    do begin
      step(rnd);
      c++;
    end while ((m_busy || pending != '0) && c < maxc);
    if (m_busy || pending != '0) begin
      n_vec++; n_fail++;
      $display("FAIL run_idle_timeout: still busy after %0d cycles, expected idle", maxc);
    end
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    req = '0;
    pending = '0;
    m_busy = 1'b0;
    rr_m = 0;
    sbq.delete();
    gq.delete();
    #1 rst_n = 1'b1;
    en = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant_bo), 32'd0);
    chk({tag, "_done"},  32'(done_bo), 32'd0);
    chk({tag, "_err"},   32'(err_o), 32'd0);
    chk({tag, "_res"},   32'(res_bo), 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_start"}, 32'(mul_start_o), 32'd0);
    chk({tag, "_mul_a"}, 32'(mul_a_bo), 32'd0);
    chk({tag, "_mul_b"}, 32'(mul_b_bo), 32'd0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < N; i++) begin
      a_r[i] = '0;
      b_r[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    #1 rst_n = 1'b1;

    // Asynchronous reset while the multiplier job is running.
    raise(2, 8'd13, 8'd13);
    c = 0;
    do begin
      @(negedge clk);
      #1;
      c++;
    end while (!(busy_o && !mul_start_o && grant_bo != '0) && c < 40);
    chk("reached_run", 32'(c < 40), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    req = '0;
    pending = '0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(busy_o), 32'd0);
    en = 1'b1;

    // Single request, square of 13.
    sync(); raise(2, 8'd13, 8'd13); predict();
    run_idle(1'b0, 100);

    // All four from reset: order 0..3, then wrap to 0 ahead of 3.
    do_reset();
    sync();
    for (int i = 0; i < N; i++) raise(i, 8'(i + 1), 8'd10);
    predict();
    run_idle(1'b0, 300);
    sync(); raise(3, 8'd2, 8'd3); raise(0, 8'd4, 8'd5); predict();
    run_idle(1'b0, 200);

    // Operands changed after grant must be ignored.
    sync(); raise(1, 8'd3, 8'd5); predict();
    c = 0;
    do begin
      step(1'b0);
      c++;
    end while (!grant_bo[1] && c < 20);
    chk("grant1_seen", 32'(grant_bo[1]), 32'd1);
    a_r[1] = 8'hFF;
    b_r[1] = 8'hFF;
    run_idle(1'b0, 100);

    // Multiplier never acknowledges: timeout error, then normal service.
    dead = 1'b1;
    sync(); raise(0, 8'd7, 8'd9); predict();
    run_idle(1'b0, 100);
    dead = 1'b0;
    sync(); raise(0, 8'd7, 8'd9); predict();
    run_idle(1'b0, 100);

    // Full-scale operands.
    sync(); raise(3, 8'hFF, 8'hFF); predict();
    run_idle(1'b0, 100);

    // Randomized traffic.
    repeat (800) step(1'b1);
    run_idle(1'b0, 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
